// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for the five-stage RISC-V pipeline. It
// combines three hazard sources into the stall/flush controls of the PC and the
// four pipeline registers:
//   - data-memory waits (highest priority; sequenced by a RUN/MEM_WAIT/FAULT FSM
//     that traps a hung memory into a sticky fault),
//   - EX-stage branch redirects,
//   - load-use hazards between the EX load and the ID instruction.
//
// Optional feature: define HAZARD_PERF_EN to build the saturating performance
// counters. With it undefined, stall_cycles/flush_events are tied to 0 and no
// counter flops exist.
//
// Parameters:
//   TIMEOUT  consecutive memory-stall cycles before fault (2..65535)
//   CNT_W    width of the performance counters
//
// Ports:
//   clk                      pipeline clock, rising edge
//   rst                      asynchronous active-low reset
//   id_rs1, id_rs2           ID-stage source register addresses
//   id_uses_rs1, id_uses_rs2 ID instruction reads that source
//   ex_a_wr                  EX-stage destination register
//   ex_RegWrite              EX instruction writes the register file
//   ex_result_src            EX result select (2'b01 = load)
//   ex_branch_taken          EX redirects the PC this cycle
//   mem_req                  MEM stage holds a valid load/store
//   dmem_ready               data memory completes the access this cycle
//   fault_clr                leaves FAULT (ignored in other states)
//   stall_pc/fd/de/em        hold PC, IF/ID, ID/EX, EX/MEM
//   flush_fd/de/mw           bubble IF/ID, ID/EX, MEM/WB
//   mem_fault                sticky memory-timeout flag (1 exactly in FAULT)
//   stall_cycles             cycles with stall_pc=1 (saturating)
//   flush_events             cycles with a branch flush applied (saturating)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_a_wr,
  input  logic             ex_RegWrite,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             fault_clr,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_de,
  output logic             stall_em,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_mw,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  // wait_cnt equal to this value on a stalled cycle means the next edge is
  // the TIMEOUT-th consecutive stall edge.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;

  logic mstall;    // memory access still outstanding (not counted in FAULT)
  logic lu;        // EX load feeds a source the ID instruction reads
  logic hold_all;  // whole front end frozen, MEM/WB bubbled

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    mstall   = (state != FAULT) && mem_req && !dmem_ready;
    lu       = (ex_result_src == 2'b01) && ex_RegWrite && (ex_a_wr != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_a_wr)) ||
                (id_uses_rs2 && (id_rs2 == ex_a_wr)));
    hold_all = (state == FAULT) || mstall;
  end

  // ---------------------------------------------------------------------------
  // State register and memory-wait counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      // Any cycle without an outstanding access (including every FAULT cycle)
      // restarts the timeout window.
      wait_cnt <= mstall ? wait_cnt + 16'd1 : 16'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block free of inferred
  // latches on paths that do not change state.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN, MEM_WAIT: begin
        if (mstall) begin
          state_nxt = (wait_cnt == WAIT_LAST) ? FAULT : MEM_WAIT;
        end else begin
          // Covers both dmem_ready completing the access and a withdrawn
          // request; either way the stall is released this cycle.
          state_nxt = RUN;
        end
      end
      FAULT: begin
        if (fault_clr) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall / flush outputs (zero latency, forced low while in reset)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    stall_de  = 1'b0;
    stall_em  = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    flush_mw  = 1'b0;
    mem_fault = 1'b0;
    if (rst) begin
      mem_fault = (state == FAULT);
      if (hold_all) begin
        // EX stays frozen, so any branch or load-use hazard is seen again
        // once the memory releases the pipeline.
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        stall_de = 1'b1;
        stall_em = 1'b1;
        flush_mw = 1'b1;
      end else if (ex_branch_taken) begin
        // The ID instruction is squashed, so a load-use hazard is moot.
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end else if (lu) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        flush_de = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             br_flush;

  // flush_fd is driven only by the branch arm of the priority chain.
  assign br_flush = flush_fd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. A behavioural model tracks only
// "is the controller faulted", the length of the current memory-stall streak
// and the two event counts; expected outputs are derived from the priority
// rules each cycle. Directed scenarios are followed by a randomized run.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 time
// units later, mid-cycle.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TB_TIMEOUT = 5;
  localparam int TB_CNT_W   = 4;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:0]          id_rs1, id_rs2;
  logic                id_uses_rs1, id_uses_rs2;
  logic [4:0]          ex_a_wr;
  logic                ex_RegWrite;
  logic [1:0]          ex_result_src;
  logic                ex_branch_taken;
  logic                mem_req, dmem_ready, fault_clr;
  logic                stall_pc, stall_fd, stall_de, stall_em;
  logic                flush_fd, flush_de, flush_mw, mem_fault;
  logic [TB_CNT_W-1:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_a_wr        (ex_a_wr),
    .ex_RegWrite    (ex_RegWrite),
    .ex_result_src  (ex_result_src),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .dmem_ready     (dmem_ready),
    .fault_clr      (fault_clr),
    .stall_pc       (stall_pc),
    .stall_fd       (stall_fd),
    .stall_de       (stall_de),
    .stall_em       (stall_em),
    .flush_fd       (flush_fd),
    .flush_de       (flush_de),
    .flush_mw       (flush_mw),
    .mem_fault      (mem_fault),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  always #5 clk = ~clk;

  // {stall_pc, stall_fd, stall_de, stall_em, flush_fd, flush_de, flush_mw, mem_fault}
  wire [7:0] obs = {stall_pc, stall_fd, stall_de, stall_em,
                    flush_fd, flush_de, flush_mw, mem_fault};

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_fault;
  int m_streak;
  int m_stall_cnt;
  int m_flush_cnt;

  function automatic logic [7:0] model_outputs();
    logic [7:0] o;
    bit         load_use;
    bit         mem_busy;
    o = 8'b0;
    if (!rst) return o;
    load_use = (ex_result_src == 2'b01) && ex_RegWrite && (ex_a_wr != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_a_wr) || (id_uses_rs2 && id_rs2 == ex_a_wr));
    mem_busy = !m_fault && mem_req && !dmem_ready;
    if (m_fault || mem_busy) o = 8'b1111_0010;
    else if (ex_branch_taken) o = 8'b0000_1100;
    else if (load_use) o = 8'b1100_0100;
    o[0] = m_fault;
    return o;
  endfunction

  function automatic int exp_stall_cycles();
`ifdef HAZARD_PERF_EN
    return m_stall_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush_events();
`ifdef HAZARD_PERF_EN
    return m_flush_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_fault     = 1'b0;
    m_streak    = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Advance the model across one rising edge, using the inputs present there.
  task automatic model_edge();
    logic [7:0] o;
    if (!rst) begin
      model_reset();
      return;
    end
    o = model_outputs();
    if (o[7] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (o[3] && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    if (m_fault) begin
      if (fault_clr) begin
        m_fault  = 1'b0;
        m_streak = 0;
      end
    end else if (mem_req && !dmem_ready) begin
      m_streak++;
      if (m_streak == TB_TIMEOUT) begin
        m_fault  = 1'b1;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    ex_a_wr         = 5'd0;
    ex_RegWrite     = 1'b0;
    ex_result_src   = 2'b00;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    dmem_ready      = 1'b0;
    fault_clr       = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] wr, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    ex_result_src = 2'b01;
    ex_RegWrite   = 1'b1;
    ex_a_wr       = wr;
    id_rs1        = rs1;
    id_uses_rs1   = u1;
    id_rs2        = rs2;
    id_uses_rs2   = u2;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] exp_o;
    set_idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    checks++;
    exp_o = model_outputs();
    if (obs !== exp_o || stall_cycles !== 0 || flush_events !== 0) begin
      failures++;
      $display("FAIL reset_state got=%b/%0d/%0d want=%b/0/0", obs, stall_cycles, flush_events, exp_o);
    end
    rst = 1'b1;
    tick();
    #3;
    checks++;
    if (obs !== 8'b0) begin
      failures++;
      $display("FAIL reset_release_idle got=%b want=00000000", obs);
    end
    set_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    // wr, rs1, u1, rs2, u2, expected outputs
    logic [4:0] tw  [5] = '{5'd5, 5'd0, 5'd5, 5'd7, 5'd9};
    logic [4:0] tr1 [5] = '{5'd5, 5'd0, 5'd5, 5'd1, 5'd9};
    logic       tu1 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] tr2 [5] = '{5'd3, 5'd0, 5'd2, 5'd7, 5'd9};
    logic       tu2 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] texp[5] = '{8'b1100_0100, 8'b0, 8'b0, 8'b1100_0100, 8'b1100_0100};
    logic [7:0] exp_o;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      set_load(tw[i], tr1[i], tu1[i], tr2[i], tu2[i]);
      #3;
      checks++;
      exp_o = model_outputs();
      if (obs !== texp[i] || obs !== exp_o) begin
        failures++;
        $display("FAIL load_use[%0d] got=%b want=%b model=%b", i, obs, texp[i], exp_o);
      end
      tick();
    end
    // Not a load: same registers, no hazard.
    set_idle();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_result_src = 2'b00;
    #3;
    checks++;
    if (obs !== 8'b0) begin
      failures++;
      $display("FAIL load_use_not_load got=%b want=00000000", obs);
    end
    tick();
    set_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch_priority();
    logic [7:0] exp_o;
    set_idle();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_branch_taken = 1'b1;
    #3;
    checks++;
    exp_o = model_outputs();
    if (obs !== 8'b0000_1100 || obs !== exp_o) begin
      failures++;
      $display("FAIL branch_over_lu got=%b want=00001100", obs);
    end
    tick();
    set_idle();
    #3;
    checks++;
    if (flush_events !== TB_CNT_W'(exp_flush_events())) begin
      failures++;
      $display("FAIL branch_flush_count got=%0d want=%0d", flush_events, exp_flush_events());
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mem_wait();
    logic [7:0] exp_o;
    int         stalled;
    stalled = 0;
    set_idle();
    for (int c = 0; c < 4; c++) begin
      mem_req         = 1'b1;
      dmem_ready      = (c == 3);
      ex_branch_taken = (c == 1);
      #3;
      checks++;
      exp_o = model_outputs();
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL mem_wait[%0d] got=%b want=%b", c, obs, exp_o);
      end
      if (stall_em) stalled++;
      tick();
    end
    checks++;
    if (stalled !== 3) begin
      failures++;
      $display("FAIL mem_wait_stall_len got=%0d want=3", stalled);
    end
    // Back in RUN: a new load-use hazard is acted on immediately.
    set_idle();
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    #3;
    checks++;
    if (obs !== 8'b1100_0100) begin
      failures++;
      $display("FAIL mem_wait_back_to_run got=%b want=11000100", obs);
    end
    tick();
    // Withdrawn request releases the stall in that cycle.
    set_idle();
    mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    #3;
    checks++;
    exp_o = model_outputs();
    if (obs !== 8'b0 || obs !== exp_o) begin
      failures++;
      $display("FAIL mem_wait_withdraw got=%b want=00000000", obs);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fault();
    logic [7:0] exp_o;
    int         edges;
    bit         seen;
    set_idle();
    mem_req = 1'b1;
    edges   = 0;
    seen    = 1'b0;
    while (!seen && edges < TB_TIMEOUT + 3) begin
      #3;
      checks++;
      exp_o = model_outputs();
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL fault_approach[%0d] got=%b want=%b", edges, obs, exp_o);
      end
      tick();
      edges++;
      seen = (mem_fault === 1'b1);
    end
    checks++;
    if (!seen || edges !== TB_TIMEOUT) begin
      failures++;
      $display("FAIL fault_edge got=%0d (seen=%0d) want=%0d", edges, seen, TB_TIMEOUT);
    end
    // Fault is sticky even if memory becomes ready or the request drops.
    for (int c = 0; c < 10; c++) begin
      dmem_ready      = c[0];
      mem_req         = (c < 5);
      ex_branch_taken = (c == 3);
      #3;
      checks++;
      exp_o = model_outputs();
      if (obs !== 8'b1111_0011 || obs !== exp_o) begin
        failures++;
        $display("FAIL fault_sticky[%0d] got=%b want=11110011", c, obs);
      end
      tick();
    end
    set_idle();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    #3;
    checks++;
    if (obs !== 8'b0 || mem_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear got=%b want=00000000", obs);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_counters();
    int want_s, want_f;
    set_idle();
    rst = 1'b0;
    #2;
    model_reset();
    rst = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      mem_req         = (c < 4);
      dmem_ready      = (c == 3);
      ex_branch_taken = (c == 4 || c == 5);
      tick();
    end
    set_idle();
`ifdef HAZARD_PERF_EN
    want_s = 3;
    want_f = 2;
`else
    want_s = 0;
    want_f = 0;
`endif
    #3;
    checks++;
    if (stall_cycles !== TB_CNT_W'(want_s) || flush_events !== TB_CNT_W'(want_f)) begin
      failures++;
      $display("FAIL perf_counters got=%0d/%0d want=%0d/%0d", stall_cycles, flush_events, want_s, want_f);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_wait();
    set_idle();
    mem_req = 1'b1;
    branch_and_load:
    begin
      set_load(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
      ex_branch_taken = 1'b1;
    end
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 8'b0 || stall_cycles !== 0 || flush_events !== 0) begin
      failures++;
      $display("FAIL reset_async got=%b/%0d/%0d want=00000000/0/0", obs, stall_cycles, flush_events);
    end
    tick();
    #2;
    set_idle();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #3;
      checks++;
      if (obs !== 8'b0 || stall_cycles !== 0 || flush_events !== 0) begin
        failures++;
        $display("FAIL reset_release[%0d] got=%b/%0d/%0d want=00000000/0/0", c, obs, stall_cycles, flush_events);
      end
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [7:0] exp_o;
    for (int c = 0; c < 600; c++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_a_wr         = 5'($urandom_range(0, 3));
      ex_RegWrite     = ($urandom_range(0, 3) != 0);
      ex_result_src   = 2'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req         = ($urandom_range(0, 2) != 0);
      dmem_ready      = ($urandom_range(0, 2) == 0);
      fault_clr       = ($urandom_range(0, 7) == 0);
      #3;
      checks++;
      exp_o = model_outputs();
      if (obs !== exp_o ||
          stall_cycles !== TB_CNT_W'(exp_stall_cycles()) ||
          flush_events !== TB_CNT_W'(exp_flush_events())) begin
        failures++;
        $display("FAIL random[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", c, obs, stall_cycles,
                 flush_events, exp_o, exp_stall_cycles(), exp_flush_events());
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_fault();
    test_counters();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. It watches ID-stage source registers, the EX-stage destination/result-source, the EX branch-redirect, and the data-memory ready handshake. From these it drives the `stall`/`flush` inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM sequences multi-cycle data-memory waits and traps a hung memory with a sticky fault.

## Interface
Parameters:
- `TIMEOUT`, 255: consecutive memory-stall cycles before fault; legal range 2..65535.
- `CNT_W`, 32: width of performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5  ID-stage source register addresses.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the ID instruction reads that source.
- `ex_a_wr`  in  5  EX-stage destination register.
- `ex_RegWrite`  in  1  EX instruction writes the register file.
- `ex_result_src`  in  2  EX result select; `2'b01` = load.
- `ex_branch_taken`  in  1  EX redirects the PC this cycle.
- `mem_req`  in  1  MEM stage has a valid load/store.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `fault_clr`  in  1  clears FAULT.
- `stall_pc`, `stall_fd`, `stall_de`, `stall_em`  out  1  hold PC / IF/ID / ID/EX / EX/MEM.
- `flush_fd`, `flush_de`, `flush_mw`  out  1  bubble IF/ID / ID/EX / MEM/WB.
- `mem_fault`  out  1  sticky memory-timeout flag.
- `stall_cycles`, `flush_events`  out  `CNT_W`  performance counters.

## Operation
- The FSM has three states: RUN, MEM_WAIT and FAULT.
- A memory stall (`mstall`) is `mem_req & ~dmem_ready` in RUN or MEM_WAIT.
- A load-use hazard (`lu`) holds when all of the following are true:
  - `ex_result_src==2'b01`, `ex_RegWrite`, and `ex_a_wr!=0`;
  - `(id_uses_rs1 & id_rs1==ex_a_wr) | (id_uses_rs2 & id_rs2==ex_a_wr)`.
- Output priority, evaluated combinationally each cycle:
  1. FAULT state or `mstall`: `stall_pc=stall_fd=stall_de=stall_em=1`, `flush_mw=1`. All other flushes are 0, and branch and load-use are suppressed. EX is frozen, so the branch and the hazard are re-presented on release.
  2. `ex_branch_taken`: `flush_fd=flush_de=1`. No stalls; load-use is ignored because the ID instruction is squashed.
  3. `lu`: `stall_pc=stall_fd=1` and `flush_de=1`.
  4. Otherwise all outputs are 0.
- State transitions:
  - RUN → MEM_WAIT on `mstall`.
  - MEM_WAIT → RUN on `dmem_ready`. Stalls drop in that same cycle and MEM/WB captures the access.
  - RUN/MEM_WAIT → FAULT when `mstall` and `wait_cnt==TIMEOUT-1`.
  - FAULT → RUN only on `fault_clr`. `fault_clr` is ignored in other states.
- `wait_cnt` (16 bit) increments on every `mstall` cycle. It clears on any non-`mstall` cycle and on FAULT exit.
- `mem_fault` is 1 exactly while in FAULT.
- `mem_req` dropping in MEM_WAIT releases the stall in that cycle and returns the FSM to RUN. The memory must not withdraw a request; this is a protocol error.

## Timing
- Stall and flush outputs have zero latency: they are combinational from inputs and registered state. Pipeline registers act on the next clock edge.
- A memory access with `dmem_ready` low for N cycles (N < `TIMEOUT`) gives N stall cycles. The access completes on cycle N+1.
- The fault is visible at edge `TIMEOUT` after the first stalled cycle.
- Reset (`rst` low, asynchronous, any state including mid-MEM_WAIT):
  - state becomes RUN, and `wait_cnt`, `stall_cycles` and `flush_events` become 0;
  - all stall and flush outputs and `mem_fault` are forced to 0 while `rst` is low.
- Counters saturate at all-ones, with no wrap:
  - `stall_cycles` increments on every cycle with `stall_pc=1`;
  - `flush_events` increments on every cycle where the branch flush (priority 2) is applied.

## Configuration
- `HAZARD_PERF_EN` defined: `stall_cycles` and `flush_events` are implemented as described.
- `HAZARD_PERF_EN` undefined: no counter flops are built, and both outputs are tied to 0. Stall, flush and fault behaviour is identical in both builds.

## Test plan
- Load-use: `ex_result_src=01`, `ex_RegWrite=1`, `ex_a_wr=5`, `id_rs1=5`, `id_uses_rs1=1` → `stall_pc=stall_fd=flush_de=1` in the same cycle. Repeat with `ex_a_wr=0` or `id_uses_rs1=0` → all outputs 0.
- Branch plus load-use in the same cycle → `flush_fd=flush_de=1`, `stall_pc=0`, and `flush_events` increments by 1.
- `TIMEOUT=8`; `mem_req=1` with `dmem_ready` low for 3 cycles, then high → 3 cycles of `stall_pc/fd/de/em=1` and `flush_mw=1`. A `ex_branch_taken` pulse during the wait produces no `flush_fd`. On the 4th cycle all outputs are 0 and the state is RUN.
- `TIMEOUT=4`; `mem_req=1`, `dmem_ready` held low → `mem_fault=1` at edge 4 and stalls held. After 10 further cycles it is still in FAULT. A 1-cycle `fault_clr` pulse → RUN and `mem_fault=0` on the next edge.
- `rst` asserted low mid-MEM_WAIT → outputs 0 asynchronously. After release with `mem_req=0`, the controller stays in RUN with counters at 0.
- With `HAZARD_PERF_EN` defined, apply 3 memory-stall cycles and 2 branch flushes → `stall_cycles=3`, `flush_events=2`. With it undefined, both read 0.
